// File: rtl/mem_burst_responder.sv
// ---------------------------------------------------------------------------
// mem_burst_responder
//   Memory-side responder for a cache refill/writeback port. Accepts one
//   command at a time. Write bursts are absorbed beat by beat with byte
//   masks. Read bursts are returned after a fixed latency. The storage is a
//   word array indexed by the low DEPTH_LOG2 address bits. Higher address
//   bits alias onto the same storage.
//
//   Optional feature macro: MEM_RESP_CRITICAL_WORD_FIRST_EN
//     defined   : a read burst starts at the requested word (addr low bits)
//                 and then wraps inside the line.
//     undefined : a read burst always starts at beat 0 of the line.
//   Writes always start at beat 0 in both builds.
//
//   Timing (edges counted from the accept edge e0):
//     - write: mem_req_data_ready is high from e0 until the edge that takes
//       beat BEATS-1. mem_req_rdy returns after that edge.
//     - read : mem_resp_val is high after edges e0+RD_LATENCY through
//       e0+RD_LATENCY+BEATS-1. mem_req_rdy returns after the edge that
//       follows the last beat.
//   BEATS must be a power of two and at least 2. DEPTH_LOG2 must exceed
//   log2(BEATS), and ADDR_BITS must exceed DEPTH_LOG2.
// ---------------------------------------------------------------------------
module mem_burst_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int BEATS      = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LATENCY = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_val,
  output logic                   mem_req_rdy,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic                   mem_req_rw,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_val,
  output logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int LAT_W  = $clog2(RD_LATENCY + 1);
  localparam int LINE_W = DEPTH_LOG2 - BEAT_W;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int MASK_W = DATA_BITS / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_RWAIT,
    S_RDATA
  } state_e;

  // Registered state and outputs
  state_e               state_q,      state_d;
  logic                 rdy_q,        rdy_d;
  logic                 dready_q,     dready_d;
  logic                 resp_val_q,   resp_val_d;
  logic [DATA_BITS-1:0] resp_data_q,  resp_data_d;
  logic [LINE_W-1:0]    line_q,       line_d;
  logic [BEAT_W-1:0]    start_q,      start_d;
  logic [BEAT_W-1:0]    beat_q,       beat_d;
  logic [LAT_W-1:0]     lat_q,        lat_d;

  // Backing store
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  wr_beat;
  logic [BEAT_W-1:0]     rd_start;
  logic [BEAT_W-1:0]     beat_off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_addr;

  // rdy_q is only ever set while idle, so it alone qualifies the handshake.
  assign accept  = mem_req_val & rdy_q;
  assign wr_beat = (state_q == S_WDATA) & mem_req_data_valid & dready_q;

  // The beat offset wraps modulo BEATS, so a burst never leaves its line.
  assign beat_off = start_q + beat_q;
  assign idx      = {line_q, beat_off};

`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
  assign rd_start = mem_req_addr[BEAT_W-1:0];
`else
  assign rd_start = '0;
`endif

  // Address bits above the array depth alias silently. In the default build
  // the word-in-line bits are also ignored.
  assign unused_addr = ^{mem_req_addr[ADDR_BITS-1:DEPTH_LOG2],
                         mem_req_addr[BEAT_W-1:0]};

  // Next-state and next-output logic for the command/burst FSM
  always_comb begin
    // NOTE: every signal gets a default here. Without the defaults, a path
    // that does not assign a signal would infer a latch.
    state_d     = state_q;
    rdy_d       = rdy_q;
    dready_d    = dready_q;
    resp_val_d  = 1'b0;
    resp_data_d = resp_data_q;
    line_d      = line_q;
    start_d     = start_q;
    beat_d      = beat_q;
    lat_d       = lat_q;

    unique case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          rdy_d  = 1'b0;
          line_d = mem_req_addr[DEPTH_LOG2-1:BEAT_W];
          beat_d = '0;
          lat_d  = '0;
          if (mem_req_rw) begin
            state_d  = S_WDATA;
            dready_d = 1'b1;
            start_d  = '0;
          end else begin
            state_d = S_RWAIT;
            start_d = rd_start;
          end
        end
      end

      S_WDATA: begin
        if (wr_beat) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d  = S_IDLE;
            dready_d = 1'b0;
            rdy_d    = 1'b1;
          end
        end
      end

      S_RWAIT: begin
        // On the last wait cycle, beat 0 is launched (beat_q is still zero).
        if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
          state_d     = S_RDATA;
          resp_val_d  = 1'b1;
          resp_data_d = mem_q[idx];
          beat_d      = beat_q + BEAT_W'(1);
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_RDATA: begin
        // beat_q wraps back to zero once all BEATS beats have been launched.
        if (beat_q == '0) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end else begin
          resp_val_d  = 1'b1;
          resp_data_d = mem_q[idx];
          beat_d      = beat_q + BEAT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge, whatever the statement order.
    if (!reset) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      dready_q    <= 1'b0;
      resp_val_q  <= 1'b0;
      resp_data_q <= '0;
      line_q      <= '0;
      start_q     <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      dready_q    <= dready_d;
      resp_val_q  <= resp_val_d;
      resp_data_q <= resp_data_d;
      line_q      <= line_d;
      start_q     <= start_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
    end
  end

  // Byte-masked write port for the backing store
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset. Its contents survive reset,
    // and it can then map onto block RAM with byte enables.
    if (reset && wr_beat) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (mem_req_data_mask[b]) begin
          mem_q[idx][8*b +: 8] <= mem_req_data_bits[8*b +: 8];
        end
      end
    end
  end

  assign mem_req_rdy        = rdy_q;
  assign mem_req_data_ready = dready_q;
  assign mem_resp_val       = resp_val_q;
  assign mem_resp_data      = resp_data_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_responder
//   Directed bench for mem_burst_responder with default parameters.
//   A table of write/read bursts (hand-computed expected beats) is applied in
//   a loop. Hand sequences follow for reset, ignored commands during a read,
//   and reset in the middle of a read burst.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_burst_responder;

  localparam int L = 8;

  localparam logic [127:0] VA  = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] VA2 = {{3{32'hAAAA_AAAA}}, 32'hAAAA_AAFF};
  localparam logic [127:0] VB  = {4{32'hBBBB_BBBB}};
  localparam logic [127:0] VC  = {4{32'hCCCC_CCCC}};
  localparam logic [127:0] VD  = {4{32'hDDDD_DDDD}};
  localparam logic [127:0] VX1 = {{3{32'h1111_1111}}, 32'h1111_11FF};
  localparam logic [127:0] VX2 = {4{32'h2222_2222}};
  localparam logic [127:0] VE0 = {4{32'h0123_4567}};
  localparam logic [127:0] VE1 = {4{32'h89AB_CDEF}};
  localparam logic [127:0] VE2 = {4{32'hFEDC_BA98}};
  localparam logic [127:0] VE3 = {4{32'h7654_3210}};
  localparam logic [127:0] VG0 = {4{32'h0000_0001}};
  localparam logic [127:0] VG1 = {4{32'h0000_0002}};
  localparam logic [127:0] VG2 = {4{32'h0000_0003}};
  localparam logic [127:0] VG3 = {4{32'h0000_0004}};
  localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};
  localparam logic [3:0][15:0] M_ALL = {4{16'hFFFF}};

  logic         clk;
  logic         reset;
  logic         mem_req_val;
  logic         mem_req_rdy;
  logic [27:0]  mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_val;
  logic [127:0] mem_resp_data;

  int n_cmp = 0;
  int n_bad = 0;

  mem_burst_responder #(
    .ADDR_BITS (28),
    .DATA_BITS (128),
    .BEATS     (4),
    .DEPTH_LOG2(12),
    .RD_LATENCY(L)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_req_val       (mem_req_val),
    .mem_req_rdy       (mem_req_rdy),
    .mem_req_addr      (mem_req_addr),
    .mem_req_rw        (mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits (mem_req_data_bits),
    .mem_req_data_mask (mem_req_data_mask),
    .mem_resp_val      (mem_resp_val),
    .mem_resp_data     (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit               is_wr;
    logic [27:0]      addr;
    int               gap;
    logic [3:0][127:0] d;   // write data, or expected read beats in arrival order
    logic [3:0][15:0]  m;
  } txn_t;

  function automatic txn_t mk(input bit w, input logic [27:0] a, input int g,
                              input logic [3:0][127:0] d, input logic [3:0][15:0] m);
    txn_t t;
    t.is_wr = w;
    t.addr  = a;
    t.gap   = g;
    t.d     = d;
    t.m     = m;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Wait (bounded) at falling edges until the command port is ready
  task automatic wait_rdy(input string name);
    int n = 0;
    while (mem_req_rdy !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rdy_wait"}, 128'(mem_req_rdy), 128'(1'b1));
  endtask

  task automatic do_write(input logic [27:0] a, input logic [3:0][127:0] d,
                          input logic [3:0][15:0] m, input int gap, input string name);
    wait_rdy(name);
    mem_req_val  = 1'b1;
    mem_req_rw   = 1'b1;
    mem_req_addr = a;
    @(negedge clk);
    mem_req_val = 1'b0;
    check({name, "_dready_on"}, 128'(mem_req_data_ready), 128'(1'b1));
    check({name, "_rdy_busy"},  128'(mem_req_rdy),        128'(1'b0));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (gap) @(negedge clk);
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = d[k];
      mem_req_data_mask  = m[k];
      @(negedge clk);
      mem_req_data_valid = 1'b0;
    end
    check({name, "_rdy_after_last"},    128'(mem_req_rdy),        128'(1'b1));
    check({name, "_dready_after_last"}, 128'(mem_req_data_ready), 128'(1'b0));
  endtask

  // Read burst. With hold set, a write command and write data stay asserted
  // for the whole burst, and none of it may be taken.
  task automatic do_read(input logic [27:0] a, input logic [3:0][127:0] e,
                         input bit hold, input string name);
    int quiet_bad = 0;
    wait_rdy(name);
    mem_req_val  = 1'b1;
    mem_req_rw   = 1'b0;
    mem_req_addr = a;
    @(negedge clk);
    if (hold) begin
      mem_req_rw         = 1'b1;
      mem_req_addr       = 28'h40;
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = JUNK;
      mem_req_data_mask  = 16'hFFFF;
    end else begin
      mem_req_val = 1'b0;
    end
    for (int i = 0; i < L; i++) begin
      if (mem_resp_val !== 1'b0 || mem_req_rdy !== 1'b0 || mem_req_data_ready !== 1'b0)
        quiet_bad++;
      @(negedge clk);
    end
    check({name, "_latency_quiet"}, 128'(quiet_bad), 128'(0));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_val_beat%0d", name, k),  128'(mem_resp_val), 128'(1'b1));
      check($sformatf("%s_data_beat%0d", name, k), mem_resp_data, e[k]);
      if (mem_req_rdy !== 1'b0 || mem_req_data_ready !== 1'b0) quiet_bad++;
      @(negedge clk);
    end
    check({name, "_busy_during_beats"}, 128'(quiet_bad), 128'(0));
    check({name, "_val_after"},  128'(mem_resp_val), 128'(1'b0));
    check({name, "_rdy_after"},  128'(mem_req_rdy),  128'(1'b1));
    check({name, "_data_hold"},  mem_resp_data,      e[3]);
    mem_req_val        = 1'b0;
    mem_req_data_valid = 1'b0;
  endtask

  txn_t tbl[10];

  initial begin
    int cnt;

    tbl[0] = mk(1, 28'h40, 0, {VD, VC, VB, VA}, M_ALL);
    tbl[1] = mk(0, 28'h40, 0, {VD, VC, VB, VA}, M_ALL);
    tbl[2] = mk(1, 28'h40, 0, {VX2, VX2, VX2, VX1}, {16'h0000, 16'h0000, 16'h0000, 16'h0001});
    tbl[3] = mk(0, 28'h40, 0, {VD, VC, VB, VA2}, M_ALL);
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    tbl[4] = mk(0, 28'h42, 0, {VB, VA2, VD, VC}, M_ALL);
`else
    tbl[4] = mk(0, 28'h42, 0, {VD, VC, VB, VA2}, M_ALL);
`endif
    tbl[5] = mk(1, 28'h7C, 2, {VE3, VE2, VE1, VE0}, M_ALL);
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    tbl[6] = mk(0, 28'h7F, 0, {VE2, VE1, VE0, VE3}, M_ALL);
`else
    tbl[6] = mk(0, 28'h7F, 0, {VE3, VE2, VE1, VE0}, M_ALL);
`endif
    tbl[7] = mk(0, 28'h1040, 0, {VD, VC, VB, VA2}, M_ALL);
    tbl[8] = mk(1, 28'hFFFFFFC, 1, {VG3, VG2, VG1, VG0}, M_ALL);
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    tbl[9] = mk(0, 28'h0000FFD, 0, {VG0, VG3, VG2, VG1}, M_ALL);
`else
    tbl[9] = mk(0, 28'h0000FFD, 0, {VG3, VG2, VG1, VG0}, M_ALL);
`endif

    reset              = 1'b0;
    mem_req_val        = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;

    // Power-up reset state
    repeat (2) @(negedge clk);
    check("por_rdy",       128'(mem_req_rdy),        128'(1'b0));
    check("por_resp_val",  128'(mem_resp_val),       128'(1'b0));
    check("por_resp_data", mem_resp_data,            128'(0));
    check("por_dready",    128'(mem_req_data_ready), 128'(1'b0));
    reset = 1'b1;
    @(negedge clk);
    check("por_rdy_release", 128'(mem_req_rdy), 128'(1'b1));

    // Table of bursts
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr)
        do_write(tbl[i].addr, tbl[i].d, tbl[i].m, tbl[i].gap, $sformatf("t%0d_wr", i));
      else
        do_read(tbl[i].addr, tbl[i].d, 1'b0, $sformatf("t%0d_rd", i));
    end

    // Command and write data held high during a read: neither may be taken
    do_read(28'h40, {VD, VC, VB, VA2}, 1'b1, "hold_rd");
    do_read(28'h40, {VD, VC, VB, VA2}, 1'b0, "hold_after_rd");

    // Reset for 3 cycles with a valid command present; the array is kept
    reset        = 1'b0;
    mem_req_val  = 1'b1;
    mem_req_rw   = 1'b0;
    mem_req_addr = 28'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_rdy_%0d", i),      128'(mem_req_rdy),  128'(1'b0));
      check($sformatf("rst_resp_val_%0d", i), 128'(mem_resp_val), 128'(1'b0));
    end
    reset       = 1'b1;
    mem_req_val = 1'b0;
    @(negedge clk);
    check("rst_rdy_release", 128'(mem_req_rdy), 128'(1'b1));
    do_read(28'h40, {VD, VC, VB, VA2}, 1'b0, "rst_kept_rd");

    // Reset asserted while beat 1 of a read is on the bus
    wait_rdy("mid_rst");
    mem_req_val  = 1'b1;
    mem_req_rw   = 1'b0;
    mem_req_addr = 28'h40;
    @(negedge clk);
    mem_req_val = 1'b0;
    repeat (L) @(negedge clk);
    check("mid_rst_beat0", mem_resp_data, VA2);
    @(negedge clk);
    check("mid_rst_beat1_val",  128'(mem_resp_val), 128'(1'b1));
    check("mid_rst_beat1_data", mem_resp_data,       VB);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_val_off", 128'(mem_resp_val), 128'(1'b0));
    check("mid_rst_rdy_off", 128'(mem_req_rdy),  128'(1'b0));
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_resp_val === 1'b1) cnt++;
    end
    check("mid_rst_no_more_beats", 128'(cnt),         128'(0));
    check("mid_rst_idle_rdy",      128'(mem_req_rdy), 128'(1'b1));
    do_read(28'h40, {VD, VC, VB, VA2}, 1'b0, "mid_rst_recover_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
